// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART serializer with a programmable bit period
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          tr_en,
  input  logic [15:0]   comp,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [LW-1:0] tx_level,
  output logic          busy,
  output logic          uart_tx
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] level;
  logic [7:0] shreg;
  logic [15:0] period, cnt;
  logic [2:0] bitcnt;
  logic tick, push, pop;
  assign tx_ready = level != LW'(DEPTH);
  assign tx_level = level;
  assign tick = cnt == period;
  assign push = tx_valid && tx_ready;
  // A new frame starts from idle, or straight out of a finishing stop bit so frames stay contiguous
  assign pop = tr_en && level != '0 && (state == IDLE || (state == STOP && tick));
  // Byte storage; validity is tracked by the pointers, so the array itself needs no reset
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= tx_data;
  end
  // Pointer and level bookkeeping; simultaneous push and pop leave the level unchanged
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      level <= level + LW'(push) - LW'(pop);
    end
  end
  // Frame sequencer; comp is captured only when a frame starts
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      uart_tx <= 1'b1;
      busy <= 1'b0;
      shreg <= '0;
      period <= '0;
      cnt <= '0;
      bitcnt <= '0;
    end else if (pop) begin
      state <= START;
      shreg <= mem[rp];
      period <= comp;
      cnt <= '0;
      bitcnt <= '0;
      uart_tx <= 1'b0;
      busy <= 1'b1;
    end else begin
      case (state)
        START: begin
          cnt <= tick ? '0 : cnt + 16'd1;
          if (tick) begin
            state <= DATA;
            uart_tx <= shreg[0];
          end
        end
        DATA: begin
          cnt <= tick ? '0 : cnt + 16'd1;
          if (tick) begin
            shreg <= shreg >> 1;
            bitcnt <= bitcnt + 3'd1;
            state <= bitcnt == 3'd7 ? STOP : DATA;
            uart_tx <= bitcnt == 3'd7 ? 1'b1 : shreg[1];
          end
        end
        STOP: begin
          cnt <= tick ? '0 : cnt + 16'd1;
          if (tick) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed scenarios checked cycle by cycle against a frame-level model
module tb_uart_tx_fifo;
  localparam int DEPTH = 8;
  localparam int LW = 4;
  logic clk = 1'b0, resetn = 1'b0, tr_en = 1'b0, tx_valid = 1'b0;
  logic [15:0] comp = '0;
  logic [7:0] tx_data = '0;
  logic tx_ready, busy, uart_tx;
  logic [LW-1:0] tx_level;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] q[$];
  bit m_act = 1'b0;
  int m_el = 0, m_per = 0;
  logic [7:0] m_cur = '0;
  logic [6:0] obs, exp_v;
  int bcnt;

  assign obs = {busy, uart_tx, tx_ready, tx_level};
  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .tr_en(tr_en), .comp(comp), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_level(tx_level), .busy(busy), .uart_tx(uart_tx)
  );

  function automatic logic mbit();
    int i;
    i = m_el / (m_per + 1);
    return !m_act ? 1'b1 : i == 0 ? 1'b0 : i == 9 ? 1'b1 : m_cur[i-1];
  endfunction

  function automatic logic [6:0] mexp();
    return {m_act, mbit(), q.size() < DEPTH, LW'(q.size())};
  endfunction

  task automatic step();
    bit endn, pop, push;
    @(posedge clk);
    cyc++;
    if (!resetn) begin
      q.delete();
      m_act = 1'b0;
      m_el = 0;
    end else begin
      endn = m_act && m_el == 10 * (m_per + 1) - 1;
      pop = tr_en && q.size() > 0 && (!m_act || endn);
      push = tx_valid && q.size() < DEPTH;
      if (pop) begin
        m_cur = q.pop_front();
        m_per = int'(comp);
        m_el = 0;
        m_act = 1'b1;
      end else if (endn) m_act = 1'b0;
      else if (m_act) m_el++;
      if (push) q.push_back(tx_data);
    end
    #1 exp_v = mexp();
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (obs !== 7'b0_1_1_0000) begin errors++; $display("FAIL reset_values: got %b want %b", obs, 7'b0_1_1_0000); end
    repeat (2) begin
      step();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset cyc %0d: got %b want %b", cyc, obs, exp_v); end
    end
    resetn = 1'b1;
  endtask

  task automatic test_single();
    comp = 16'd3; tr_en = 1'b1; tx_valid = 1'b1; tx_data = 8'h55;
    step();
    tx_valid = 1'b0;
    repeat (45) begin
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL single cyc %0d: got %b want %b", cyc, obs, exp_v); end
      step();
    end
    checks++;
    if ({busy, uart_tx} !== 2'b01) begin errors++; $display("FAIL single_end: got %b want 01", {busy, uart_tx}); end
  endtask

  task automatic test_fill();
    tr_en = 1'b0; comp = 16'd3;
    for (int i = 0; i < 9; i++) begin
      tx_valid = 1'b1; tx_data = 8'(i);
      step();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL fill cyc %0d: got %b want %b", cyc, obs, exp_v); end
    end
    tx_valid = 1'b0;
    checks++;
    if ({tx_ready, tx_level} !== 5'b0_1000) begin errors++; $display("FAIL fill_full: got %b want 01000", {tx_ready, tx_level}); end
    tr_en = 1'b1;
    repeat (8 * 40 + 5) begin
      step();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL drain cyc %0d: got %b want %b", cyc, obs, exp_v); end
    end
    checks++;
    if ({busy, tx_level} !== 5'b0_0000) begin errors++; $display("FAIL drain_end: got %b want 00000", {busy, tx_level}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [2];
    b[0] = 8'hA5; b[1] = 8'h0F;
    comp = 16'd1; tr_en = 1'b1; bcnt = 0;
    for (int i = 0; i < 2; i++) begin
      tx_valid = 1'b1; tx_data = b[i];
      step();
      bcnt += int'(busy);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL b2b cyc %0d: got %b want %b", cyc, obs, exp_v); end
    end
    tx_valid = 1'b0;
    repeat (44) begin
      step();
      bcnt += int'(busy);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL b2b cyc %0d: got %b want %b", cyc, obs, exp_v); end
    end
    checks++;
    if (bcnt != 40) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 40", bcnt); end
  endtask

  task automatic test_enable_drop();
    comp = 16'd2; tr_en = 1'b0;
    repeat (3) begin
      tx_valid = 1'b1; tx_data = 8'($urandom);
      step();
    end
    tx_valid = 1'b0; tr_en = 1'b1;
    repeat (12) begin
      step();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL endrop cyc %0d: got %b want %b", cyc, obs, exp_v); end
    end
    tr_en = 1'b0;
    repeat (40) begin
      step();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL endrop cyc %0d: got %b want %b", cyc, obs, exp_v); end
    end
    checks++;
    if ({busy, uart_tx, tx_level} !== 6'b01_0010) begin errors++; $display("FAIL endrop_hold: got %b want 010010", {busy, uart_tx, tx_level}); end
    tr_en = 1'b1;
    repeat (65) begin
      step();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL endrop cyc %0d: got %b want %b", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_simul_push_pop();
    comp = 16'd1; tr_en = 1'b0;
    repeat (3) begin
      tx_valid = 1'b1; tx_data = 8'($urandom);
      step();
    end
    tx_valid = 1'b0; tr_en = 1'b1;
    repeat (20) begin
      step();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL simul cyc %0d: got %b want %b", cyc, obs, exp_v); end
    end
    tx_valid = 1'b1; tx_data = 8'($urandom);
    step();
    tx_valid = 1'b0;
    checks++;
    if (tx_level !== 4'd2) begin errors++; $display("FAIL simul_level: got %0d want 2", tx_level); end
    repeat (65) begin
      step();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL simul cyc %0d: got %b want %b", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    comp = 16'd2; tr_en = 1'b0;
    repeat (2) begin
      tx_valid = 1'b1; tx_data = 8'($urandom);
      step();
    end
    tx_valid = 1'b0; tr_en = 1'b1;
    step();
    repeat (13) begin
      step();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rstmid cyc %0d: got %b want %b", cyc, obs, exp_v); end
    end
    #2 resetn = 1'b0;
    #1;
    q.delete();
    m_act = 1'b0;
    checks++;
    if (obs !== 7'b0_1_1_0000) begin errors++; $display("FAIL rstmid_async: got %b want %b", obs, 7'b0_1_1_0000); end
    step();
    step();
    resetn = 1'b1;
    repeat (40) begin
      step();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rstmid cyc %0d: got %b want %b", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      tr_en = $urandom_range(0, 9) != 0;
      tx_valid = $urandom_range(0, 2) == 0;
      tx_data = 8'($urandom);
      comp = i < 700 ? 16'($urandom_range(0, 2)) : 16'd0;
      step();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random cyc %0d: got %b want %b", cyc, obs, exp_v); end
    end
    tr_en = 1'b1; tx_valid = 1'b0;
    repeat (DEPTH * 30 + 10) begin
      step();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rdrain cyc %0d: got %b want %b", cyc, obs, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_enable_drop();
    test_simul_push_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
